// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution sequencer:
//   - CONV_AW       default X/Y address width
//   - conv_state_t  sequencer FSM state encoding
//   - is_busy_state helper: states in which the sequencer reports busy
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int CONV_AW = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADDR  = 3'd2,
    DRAIN = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } conv_state_t;

  // busy covers every state of an active run except the final DONE cycle
  function automatic logic is_busy_state(input conv_state_t s);
    return (s == CLR) || (s == ADDR) || (s == DRAIN) || (s == WR);
  endfunction

endpackage

// File: rtl/conv_index_gen.sv
// -----------------------------------------------------------------------------
// conv_index_gen
// Index generator for the convolution sequencer. Holds the output index n and
// the inner index k, derives the k range for the current n and produces the
// X/Y read addresses.
//
//   Z[n] = sum_{k=kmin..kmax} X[k]*Y[n-k]
//   kmin = max(0, n-sizeY+1), kmax = min(n, sizeX-1)
//
// Ports
//   clk        in   1    clock, posedge
//   rst_a      in   1    asynchronous reset, active low
//   init_i     in   1    latch sizes, n <= 0 (accepted start)
//   kload_i    in   1    k <= kmin (CLR cycle)
//   kstep_i    in   1    k <= k+1 (ADDR cycle, not last k)
//   nstep_i    in   1    n <= n+1 (WR cycle, not last n)
//   size_x_i   in   AW   number of X samples
//   size_y_i   in   AW   number of Y samples
//   x_addr_o   out  AW   X read address (= k)
//   y_addr_o   out  AW   Y read address (= n-k)
//   n_o        out  ZAW  current output index
//   last_k_o   out  1    k has reached kmax
//   last_n_o   out  1    n is the last output index
// -----------------------------------------------------------------------------
module conv_index_gen
  import conv_pkg::*;
#(
  parameter int AW  = CONV_AW,
  parameter int ZAW = AW + 1
) (
  input  logic           clk,
  input  logic           rst_a,
  input  logic           init_i,
  input  logic           kload_i,
  input  logic           kstep_i,
  input  logic           nstep_i,
  input  logic [AW-1:0]  size_x_i,
  input  logic [AW-1:0]  size_y_i,
  output logic [AW-1:0]  x_addr_o,
  output logic [AW-1:0]  y_addr_o,
  output logic [ZAW-1:0] n_o,
  output logic           last_k_o,
  output logic           last_n_o
);

  localparam int ZW1 = ZAW + 1;

  logic [AW-1:0]  size_x_q, size_y_q;
  logic [ZAW-1:0] n_q, n_d;
  logic [ZAW-1:0] k_q, k_d;
  logic [AW-1:0]  x_addr_q, y_addr_q;
  logic [AW-1:0]  y_addr_d;
  logic [ZAW-1:0] kmin, kmax, sx_m1, n_last;
  logic [ZW1-1:0] n_p1, sy_w;

  always_comb begin
    // n+1 and sizeY compared one bit wider so n near 2**ZAW-1 cannot wrap
    n_p1   = ZW1'(n_q) + ZW1'(1);
    sy_w   = ZW1'(size_y_q);
    kmin   = (n_p1 > sy_w) ? ZAW'(n_p1 - sy_w) : '0;
    sx_m1  = ZAW'(size_x_q) - ZAW'(1);
    kmax   = (n_q < sx_m1) ? n_q : sx_m1;
    n_last = ZAW'(size_x_q) + ZAW'(size_y_q) - ZAW'(2);

    k_d = k_q;
    if (kload_i) begin
      k_d = kmin;
    end else if (kstep_i) begin
      k_d = k_q + ZAW'(1);
    end

    n_d = n_q;
    if (init_i) begin
      n_d = '0;
    end else if (nstep_i) begin
      n_d = n_q + ZAW'(1);
    end

    // k <= n by construction, so the truncated difference is the true index
    y_addr_d = AW'(n_q - k_d);
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      size_x_q <= '0;
      size_y_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      x_addr_q <= '0;
      y_addr_q <= '0;
    end else begin
      if (init_i) begin
        size_x_q <= size_x_i;
        size_y_q <= size_y_i;
      end
      n_q <= n_d;
      k_q <= k_d;
      if (kload_i || kstep_i) begin
        x_addr_q <= AW'(k_d);
        y_addr_q <= y_addr_d;
      end
    end
  end

  // ">=" rather than "==" so out-of-contract sizes (kmin > kmax) still end ADDR
  assign last_k_o = (k_q >= kmax);
  assign last_n_o = (n_q == n_last);
  assign x_addr_o = x_addr_q;
  assign y_addr_o = y_addr_q;
  assign n_o      = n_q;

endmodule

// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
// Control FSM sequencing the 8x8->16 MAC of the convolution IP:
//   Z[n] = sum_k X[k]*Y[n-k], n = 0..sizeX+sizeY-2
// Per output: CLR (clear MAC) -> ADDR (K_n address cycles) -> DRAIN -> WR,
// then DONE for one cycle after the last write.
//
// Ports
//   clk        in   1    clock, posedge
//   rst_a      in   1    asynchronous reset, active low
//   start      in   1    start pulse, sizes latched; ignored unless idle
//   sizeX      in   AW   number of X samples (1..2**AW-1)
//   sizeY      in   AW   number of Y samples (1..2**AW-1)
//   busy       out  1    run in progress (CLR/ADDR/DRAIN/WR)
//   done       out  1    one-cycle pulse after the last Z write
//   memX_addr  out  AW   X read address, data valid one cycle later
//   memY_addr  out  AW   Y read address, data valid one cycle later
//   memZ_addr  out  ZAW  Z write address (= n)
//   memZ_we    out  1    Z write enable, data = MAC accumulator
//   mac_clr_n  out  1    MAC synchronous clear, active low
//   mac_load   out  1    MAC accumulate enable
//   int_o      out  1    sticky done interrupt
//   int_clr    in   1    interrupt clear
//
// Configuration
//   CONV_INT_EN  defined: int_o set on DONE and held until int_clr (set wins).
//                undefined: int_o tied low, int_clr ignored.
// -----------------------------------------------------------------------------
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int AW  = CONV_AW,
  parameter int ZAW = AW + 1
) (
  input  logic           clk,
  input  logic           rst_a,
  input  logic           start,
  input  logic [AW-1:0]  sizeX,
  input  logic [AW-1:0]  sizeY,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  memX_addr,
  output logic [AW-1:0]  memY_addr,
  output logic [ZAW-1:0] memZ_addr,
  output logic           memZ_we,
  output logic           mac_clr_n,
  output logic           mac_load,
  output logic           int_o,
  input  logic           int_clr
);

  conv_state_t state_q, state_d;

  logic busy_q, done_q, memZ_we_q, mac_clr_n_q;
  logic load_vld_q;
  logic init, kload, kstep, nstep;
  logic last_k, last_n;

  conv_index_gen #(
    .AW  (AW),
    .ZAW (ZAW)
  ) u_index_gen (
    .clk      (clk),
    .rst_a    (rst_a),
    .init_i   (init),
    .kload_i  (kload),
    .kstep_i  (kstep),
    .nstep_i  (nstep),
    .size_x_i (sizeX),
    .size_y_i (sizeY),
    .x_addr_o (memX_addr),
    .y_addr_o (memY_addr),
    .n_o      (memZ_addr),
    .last_k_o (last_k),
    .last_n_o (last_n)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLR;
      CLR:     state_d = ADDR;
      ADDR:    if (last_k) state_d = DRAIN;
      DRAIN:   state_d = WR;
      WR:      state_d = last_n ? DONE : CLR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    init  = (state_q == IDLE) && start;
    kload = (state_q == CLR);
    kstep = (state_q == ADDR) && !last_k;
    nstep = (state_q == WR) && !last_n;
  end

  // Outputs are registered from the next state so they line up with the state.
  // mac_load is ADDR delayed by one cycle to match the memory read latency;
  // it can never coincide with CLR, which always follows IDLE or WR.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      memZ_we_q   <= 1'b0;
      mac_clr_n_q <= 1'b1;
      load_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= is_busy_state(state_d);
      done_q      <= (state_d == DONE);
      memZ_we_q   <= (state_d == WR);
      mac_clr_n_q <= (state_d != CLR);
      load_vld_q  <= (state_q == ADDR);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign memZ_we   = memZ_we_q;
  assign mac_clr_n = mac_clr_n_q;
  assign mac_load  = load_vld_q;

`ifdef CONV_INT_EN
  logic int_q, int_d;

  // Set covers both the edge entering DONE and the DONE cycle itself, so an
  // int_clr coinciding with DONE cannot win over the set.
  always_comb begin
    int_d = (state_d == DONE) || (state_q == DONE) || (int_q && !int_clr);
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      int_q <= 1'b0;
    end else begin
      int_q <= int_d;
    end
  end

  assign int_o = int_q;
`else
  logic unused_int_clr;
  assign unused_int_clr = int_clr;
  assign int_o = 1'b0;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;

  localparam int AW  = 5;
  localparam int ZAW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a, start, int_clr, tb_clear;
  logic [AW-1:0]  sizeX, sizeY;
  logic           busy, done, memZ_we, mac_clr_n, mac_load, int_o;
  logic [AW-1:0]  memX_addr, memY_addr;
  logic [ZAW-1:0] memZ_addr;

  conv_sequencer #(.AW(AW), .ZAW(ZAW)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .start     (start),
    .sizeX     (sizeX),
    .sizeY     (sizeY),
    .busy      (busy),
    .done      (done),
    .memX_addr (memX_addr),
    .memY_addr (memY_addr),
    .memZ_addr (memZ_addr),
    .memZ_we   (memZ_we),
    .mac_clr_n (mac_clr_n),
    .mac_load  (mac_load),
    .int_o     (int_o),
    .int_clr   (int_clr)
  );

  // Environment: X/Y memories with 1-cycle read latency, MAC, Z memory
  logic [7:0]  xmem [32];
  logic [7:0]  ymem [32];
  logic [7:0]  xd, yd;
  logic [15:0] acc;
  logic [15:0] zmem [64];
  int n_wr, n_clr, n_ld, n_ovl, n_int;

  always @(posedge clk) begin
    xd <= xmem[memX_addr];
    yd <= ymem[memY_addr];
    if (!mac_clr_n) acc <= 16'd0;
    else if (mac_load) acc <= acc + ({8'd0, xd} * {8'd0, yd});
    if (tb_clear) begin
      n_wr <= 0; n_clr <= 0; n_ld <= 0; n_ovl <= 0; n_int <= 0;
      for (int i = 0; i < 64; i++) zmem[i] <= 16'hDEAD;
    end else begin
      if (memZ_we) begin
        zmem[memZ_addr] <= acc;
        n_wr <= n_wr + 1;
      end
      if (!mac_clr_n) n_clr <= n_clr + 1;
      if (mac_load) n_ld <= n_ld + 1;
      if (!mac_clr_n && mac_load) n_ovl <= n_ovl + 1;
      if (int_o) n_int <= n_int + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc;
  int exp5[6];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_env();
    @(negedge clk); tb_clear = 1'b1;
    @(negedge clk); tb_clear = 1'b0;
  endtask

  // One run: accepted start is the edge after 'start' is raised; cycles counts
  // edges from that accept edge to the first sample showing done.
  task automatic run_conv(input int sx, input int sy, input bit extra,
                          input bit clr_at_done, output int cycles);
    clear_env();
    sizeX = AW'(sx); sizeY = AW'(sy); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    chk("busy_after_start", busy, 1);
    while (!done && cycles < 3000) begin
      if (extra) begin
        start = (cycles % 3 == 0);
        sizeX = AW'(cycles);
        sizeY = AW'(cycles + 7);
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_in_done", busy, 0);
`ifdef CONV_INT_EN
    chk("int_at_done", int_o, 1);
`else
    chk("int_at_done", int_o, 0);
`endif
    if (extra) start = 1'b1;
    int_clr = clr_at_done;
    @(posedge clk); #1;
    start = 1'b0;
    int_clr = 1'b0;
    chk("idle_after_done", busy, 0);
    chk("done_is_pulse", done, 0);
`ifdef CONV_INT_EN
    chk("int_held", int_o, 1);
    int_clr = 1'b1;
    @(posedge clk); #1;
    int_clr = 1'b0;
    chk("int_cleared", int_o, 0);
`else
    chk("int_tied_low", n_int, 0);
`endif
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_we"}, memZ_we, 0);
    chk({pfx, "_load"}, mac_load, 0);
    chk({pfx, "_clr_n"}, mac_clr_n, 1);
    chk({pfx, "_xaddr"}, memX_addr, 0);
    chk({pfx, "_yaddr"}, memY_addr, 0);
    chk({pfx, "_zaddr"}, memZ_addr, 0);
    chk({pfx, "_int"}, int_o, 0);
  endtask

  initial begin
    rst_a = 1'b0; start = 1'b0; int_clr = 1'b0; tb_clear = 1'b0;
    sizeX = '0; sizeY = '0;
    for (int i = 0; i < 32; i++) begin xmem[i] = 8'd200; ymem[i] = 8'd200; end

    repeat (2) @(posedge clk); #1;
    chk_reset_outputs("rst");
    @(negedge clk); rst_a = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // 1x1: 3*4
    xmem[0] = 8'd3; ymem[0] = 8'd4;
    run_conv(1, 1, 1'b0, 1'b0, cyc);
    chk("t1_cycles", cyc, 5);
    chk("t1_z0", zmem[0], 12);
    chk("t1_writes", n_wr, 1);
    chk("t1_loads", n_ld, 1);
    chk("t1_overlap", n_ovl, 0);

    // 3x2: X={1,2,3}, Y={1,1} -> Z={1,3,5,3}
    xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
    ymem[0] = 8'd1; ymem[1] = 8'd1;
    run_conv(3, 2, 1'b0, 1'b0, cyc);
    chk("t2_cycles", cyc, 19);
    chk("t2_z0", zmem[0], 1);
    chk("t2_z1", zmem[1], 3);
    chk("t2_z2", zmem[2], 5);
    chk("t2_z3", zmem[3], 3);
    chk("t2_writes", n_wr, 4);
    chk("t2_loads", n_ld, 6);
    chk("t2_clears", n_clr, 4);
    chk("t2_overlap", n_ovl, 0);

    // 255*255 at full operand range
    xmem[0] = 8'd255; ymem[0] = 8'd255;
    run_conv(1, 1, 1'b0, 1'b0, cyc);
    chk("t3_z0", zmem[0], 65025);
    chk("t3_clears", n_clr, 1);

    // 3x2 again with start pulses and size changes while busy and in DONE
    xmem[0] = 8'd1;
    ymem[0] = 8'd1;
    run_conv(3, 2, 1'b1, 1'b0, cyc);
    chk("t4_cycles", cyc, 19);
    chk("t4_z0", zmem[0], 1);
    chk("t4_z1", zmem[1], 3);
    chk("t4_z2", zmem[2], 5);
    chk("t4_z3", zmem[3], 3);
    chk("t4_writes", n_wr, 4);

    // 4x3 all ones -> Z[n] = K_n
    for (int i = 0; i < 32; i++) begin xmem[i] = 8'd1; ymem[i] = 8'd1; end
    exp5 = '{1, 2, 3, 3, 2, 1};
    run_conv(4, 3, 1'b0, 1'b0, cyc);
    chk("t5_cycles", cyc, 31);
    for (int i = 0; i < 6; i++) chk($sformatf("t5_z%0d", i), zmem[i], exp5[i]);
    chk("t5_loads", n_ld, 12);
    chk("t5_z6_untouched", zmem[6], 16'hDEAD);

    // maximum sizes 31x31: last n = 60, no address overflow
    run_conv(31, 31, 1'b0, 1'b0, cyc);
    chk("t6_cycles", cyc, 1145);
    chk("t6_writes", n_wr, 61);
    chk("t6_loads", n_ld, 961);
    chk("t6_z0", zmem[0], 1);
    chk("t6_z29", zmem[29], 30);
    chk("t6_z30", zmem[30], 31);
    chk("t6_z60", zmem[60], 1);
    chk("t6_z61_untouched", zmem[61], 16'hDEAD);
    chk("t6_overlap", n_ovl, 0);

    // reset in the middle of ADDR (n=1, k=1)
    clear_env();
    sizeX = 5'd31; sizeY = 5'd31; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t7_pre_busy", busy, 1);
    chk("t7_pre_xaddr", memX_addr, 1);
    chk("t7_pre_load", mac_load, 1);
    #2 rst_a = 1'b0;
    #1;
    chk_reset_outputs("t7_rst");
    clear_env();
    repeat (3) @(posedge clk);
    #1;
    chk("t7_no_write", n_wr, 0);
    chk("t7_held_busy", busy, 0);
    @(negedge clk); rst_a = 1'b1;
    xmem[0] = 8'd3; ymem[0] = 8'd4;
    run_conv(1, 1, 1'b0, 1'b0, cyc);
    chk("t7_after_cycles", cyc, 5);
    chk("t7_after_z0", zmem[0], 12);
    chk("t7_after_writes", n_wr, 1);

    // int_clr in the DONE cycle: set wins (int_held inside the task)
    run_conv(1, 1, 1'b0, 1'b1, cyc);
    chk("t8_z0", zmem[0], 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
